// File: rtl/instr_sequencer.sv
// instr_sequencer
// ---------------
// Issues instruction words from a small program buffer to a vector CPU over
// a valid/ready handshake. A run is started from IDLE with a start index and
// a length; words are issued back-to-back (one per cycle while the consumer
// is ready), the buffer index wraps modulo 32, and a one-cycle done pulse
// marks the end of the run. A stop request ends the run after the word that
// is currently offered has been accepted.
//
// Optional feature: define INSTR_SEQ_LOOP_EN to make a run that exhausts its
// length restart from the captured start index and length, so that only a
// stop request ends it. Without the macro every run is single-pass.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   rst_n        : synchronous active-low reset
//   prog_we      : program buffer write strobe (ignored while busy)
//   prog_addr    : program buffer write index
//   prog_data    : instruction word to store
//   start        : begin a run (sampled in IDLE only)
//   start_pc     : first buffer index to issue
//   len          : number of words to issue (0..32)
//   stop         : end the run after the current/next handshake
//   instruction  : registered word to the consumer (zero when not valid)
//   instr_valid  : instruction holds a word to execute
//   instr_ready  : consumer accepts instruction this cycle
//   pc           : buffer index of the word currently on instruction
//   busy         : high while running
//   done         : one-cycle pulse at the end of a run

module instr_sequencer #(
  parameter int IW    = 9,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [4:0]    prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic [4:0]    start_pc,
  input  logic [5:0]    len,
  input  logic          stop,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [4:0]    pc,
  output logic          busy,
  output logic          done
);

  localparam int AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [IW-1:0] prog_mem [DEPTH];

  state_t        state_q,     state_d;
  logic [IW-1:0] instr_q,     instr_d;
  logic          vld_q,       vld_d;
  logic [AW-1:0] pc_q,        pc_d;
  logic [5:0]    remaining_q, remaining_d;
  logic          stop_flag_q, stop_flag_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
`ifdef INSTR_SEQ_LOOP_EN
  logic [AW-1:0] start_pc_q,  start_pc_d;
  logic [5:0]    len_q,       len_d;
`endif

  logic          handshake;
  logic [AW-1:0] pc_inc;

  assign handshake = vld_q & instr_ready;
  // Natural AW-bit overflow gives the 31 -> 0 wrap.
  assign pc_inc    = pc_q + 5'd1;

  // Program buffer: no reset, so a program survives a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      prog_mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    vld_d       = vld_q;
    pc_d        = pc_q;
    remaining_d = remaining_q;
    stop_flag_d = stop_flag_q;
`ifdef INSTR_SEQ_LOOP_EN
    start_pc_d  = start_pc_q;
    len_d       = len_q;
`endif

    unique case (state_q)
      IDLE: begin
        stop_flag_d = 1'b0;
        if (start) begin
`ifdef INSTR_SEQ_LOOP_EN
          start_pc_d = start_pc;
          len_d      = len;
`endif
          if (len != 6'd0) begin
            state_d     = RUN;
            instr_d     = prog_mem[start_pc];
            pc_d        = start_pc;
            vld_d       = 1'b1;
            remaining_d = len;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        if (handshake) begin
          // A stop raised this cycle counts the same as one remembered earlier.
          if (stop_flag_q || stop) begin
            state_d     = DONE;
            vld_d       = 1'b0;
            instr_d     = '0;
            remaining_d = 6'd0;
            stop_flag_d = 1'b0;
          end else if (remaining_q > 6'd1) begin
            pc_d        = pc_inc;
            instr_d     = prog_mem[pc_inc];
            remaining_d = remaining_q - 6'd1;
          end else begin
`ifdef INSTR_SEQ_LOOP_EN
            pc_d        = start_pc_q;
            instr_d     = prog_mem[start_pc_q];
            remaining_d = len_q;
`else
            state_d     = DONE;
            vld_d       = 1'b0;
            instr_d     = '0;
            remaining_d = 6'd0;
`endif
          end
        end else if (stop) begin
          stop_flag_d = 1'b1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        stop_flag_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        instr_d = '0;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      vld_q       <= 1'b0;
      pc_q        <= '0;
      remaining_q <= '0;
      stop_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
      start_pc_q  <= '0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      vld_q       <= vld_d;
      pc_q        <= pc_d;
      remaining_q <= remaining_d;
      stop_flag_q <= stop_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef INSTR_SEQ_LOOP_EN
      start_pc_q  <= start_pc_d;
      len_q       <= len_d;
`endif
    end
  end

  assign instruction = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter IW, default 9, meaning instruction width (opcode[8:7], rs[6:5], address[4:0]).
REQ-002 SHALL have parameter DEPTH, default 32, meaning program buffer entries; index width AW = 5.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port prog_we, input, 1, program buffer write strobe.
REQ-006 SHALL have port prog_addr, input, 5, program buffer write index.
REQ-007 SHALL have port prog_data, input, IW, instruction word to store.
REQ-008 SHALL have port start, input, 1, begin issuing (sampled in IDLE only).
REQ-009 SHALL have port start_pc, input, 5, first buffer index to issue.
REQ-010 SHALL have port len, input, 6, number of instructions to issue (0..32).
REQ-011 SHALL have port stop, input, 1, request to end the run after the current handshake.
REQ-012 SHALL have port instruction, output, IW, registered instruction word to the vector CPU.
REQ-013 SHALL have port instr_valid, output, 1, instruction holds a word to execute.
REQ-014 SHALL have port instr_ready, input, 1, consumer accepts instruction this cycle.
REQ-015 SHALL have port pc, output, 5, buffer index of the word currently on instruction.
REQ-016 SHALL have port busy, output, 1, high in RUN.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at end of run.

Function
REQ-018 SHALL store prog_data at prog_addr on a rising edge with prog_we high while not busy; writes while busy SHALL be ignored.
REQ-019 SHALL implement states IDLE, RUN, DONE; the DONE state SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 IDLE with start=1 and len!=0: next cycle RUN, instruction=buf[start_pc], pc=start_pc, instr_valid=1, remaining=len (latency one cycle).
REQ-021 IDLE with start=1 and len=0: next cycle DONE, instr_valid never asserted.
REQ-022 A handshake SHALL occur when instr_valid and instr_ready are both 1; instruction and pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-023 On a handshake with remaining>1 and stop=0: pc <= pc+1 modulo 32 (31 wraps to 0), instruction <= buf[pc+1], remaining decrements, instr_valid stays 1 (back-to-back issue, one word per cycle).
REQ-024 On a handshake with remaining=1, or with stop=1: next state DONE, instr_valid <= 0.
REQ-025 stop without a handshake SHALL be remembered (sticky) and SHALL end the run at the next handshake; the pending word is still issued.
REQ-026 Whenever instr_valid=0, instruction SHALL be driven to all zeros.
REQ-027 start in RUN or DONE SHALL be ignored.
REQ-028 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-029 On rst_n=0 at a rising edge, the block SHALL enter IDLE with instruction=0, instr_valid=0, pc=0, busy=0, done=0, remaining=0, stop flag cleared, including mid-run.
REQ-030 Program buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With macro INSTR_SEQ_LOOP_EN defined, a handshake that exhausts remaining with stop flag clear SHALL reload pc=start_pc captured at start, remaining=len captured at start, and stay in RUN; only stop ends the run.
REQ-032 Without INSTR_SEQ_LOOP_EN, runs SHALL be single-pass per REQ-024.

Verification
REQ-033 Load buf[0..2]=9'h005,9'h0A3,9'h180; start_pc=0,len=3, instr_ready=1 -> instruction 005,0A3,180 on three consecutive cycles starting one cycle after start, then done pulse, instr_valid=0.
REQ-034 start_pc=30,len=4, buf[30]=9'h011,buf[31]=9'h022,buf[0]=9'h033,buf[1]=9'h044 -> pc 30,31,0,1 in order, words 011,022,033,044.
REQ-035 instr_ready low for 3 cycles on the second word -> instruction and pc held unchanged, total 3 handshakes still issued.
REQ-036 stop pulsed while instr_ready=0 during word 2 of len=10 -> word 2 issued on next handshake, then DONE; no word 3.
REQ-037 rst_n=0 during RUN at word 5 -> next cycle instr_valid=0, pc=0, busy=0; prior buffer contents reissue correctly on a new start.
REQ-038 INSTR_SEQ_LOOP_EN defined, start_pc=4,len=2 -> pc sequence 4,5,4,5,... until stop, then done pulse.
